// File: rtl/mycpu_pkg.sv
// Shared bus layouts, FSM state type and exception codes for the memory-access stage.
package mycpu_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 126;
    localparam int unsigned MS_TO_WS_BUS_WD = 84;

    // LSB positions of the execute-to-memory bus fields.
    localparam int unsigned EsInstAddrEx = 125;
    localparam int unsigned EsEret       = 124;
    localparam int unsigned EsBd         = 123;
    localparam int unsigned EsMtc0We     = 122;
    localparam int unsigned EsCp0Addr    = 117;
    localparam int unsigned EsEx         = 116;
    localparam int unsigned EsExcode     = 111;
    localparam int unsigned EsResFromCp0 = 110;
    localparam int unsigned EsLwl        = 109;
    localparam int unsigned EsLwr        = 108;
    localparam int unsigned EsRtValue    = 76;
    localparam int unsigned EsLdW        = 75;
    localparam int unsigned EsLdH        = 74;
    localparam int unsigned EsLdB        = 73;
    localparam int unsigned EsLdSign     = 72;
    localparam int unsigned EsAddrLo     = 70;
    localparam int unsigned EsGrWe       = 69;
    localparam int unsigned EsDest       = 64;
    localparam int unsigned EsAluResult  = 32;
    localparam int unsigned EsPc         = 0;

    // LSB positions of the memory-to-write-back bus fields.
    localparam int unsigned MsInstAddrEx  = 83;
    localparam int unsigned MsEret        = 82;
    localparam int unsigned MsBd          = 81;
    localparam int unsigned MsMtc0We      = 80;
    localparam int unsigned MsCp0Addr     = 75;
    localparam int unsigned MsEx          = 74;
    localparam int unsigned MsExcode      = 69;
    localparam int unsigned MsResFromCp0  = 68;
    localparam int unsigned MsGrWe        = 67;
    localparam int unsigned MsDest        = 62;
    localparam int unsigned MsFinalResult = 30;
    localparam int unsigned MsPc          = 0;

    localparam logic [4:0] ExcAdel = 5'h04;
    localparam logic [4:0] ExcAdes = 5'h05;
    localparam logic [4:0] ExcOv   = 5'h0c;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StDrop} ms_state_e;

    typedef struct packed {
        logic        inst_addr_ex;
        logic        eret;
        logic        bd;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        ex;
        logic [4:0]  excode;
        logic        res_from_cp0;
        logic        lwl;
        logic        lwr;
        logic [31:0] rt_value;
        logic        ld_w;
        logic        ld_h;
        logic        ld_b;
        logic        ld_sign;
        logic [1:0]  addr_lo;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

endpackage

// File: rtl/ms_load_align.sv
// Aligns and extends a returned data word for lw/lh/lb/lwl/lwr.
module ms_load_align (
    input  logic [31:0] rdata_i,
    input  logic [31:0] rt_value_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        ld_w_i,
    input  logic        ld_h_i,
    input  logic        ld_b_i,
    input  logic        ld_sign_i,
    input  logic        lwl_i,
    input  logic        lwr_i,
    output logic [31:0] result_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
    end

    always_comb begin
        result_o = rdata_i;
        if (ld_w_i) begin
            result_o = rdata_i;
        end else if (lwl_i) begin
            case (addr_lo_i)
                2'd0: result_o = {rdata_i[7:0], rt_value_i[23:0]};
                2'd1: result_o = {rdata_i[15:0], rt_value_i[15:0]};
                2'd2: result_o = {rdata_i[23:0], rt_value_i[7:0]};
                default: result_o = rdata_i;
            endcase
        end else if (lwr_i) begin
            case (addr_lo_i)
                2'd1: result_o = {rt_value_i[31:24], rdata_i[31:8]};
                2'd2: result_o = {rt_value_i[31:16], rdata_i[31:16]};
                2'd3: result_o = {rt_value_i[31:8], rdata_i[31:24]};
                default: result_o = rdata_i;
            endcase
        end else if (ld_h_i) begin
            result_o = {{16{ld_sign_i & half[15]}}, half};
        end else if (ld_b_i) begin
            result_o = {{24{ld_sign_i & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM read response on loads,
// aligns the returned word and hands a registered bus to write-back.
module mem_stage
    import mycpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       data_sram_rvalid,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ex_from_ws,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ex_from_ms,
    output logic [31:0]                ms_forward_data,
    output logic [4:0]                 ms_dest,
    output logic                       ms_res_from_mem,
    output logic                       ms_res_from_cp0,
    output logic                       ms_load_stall
);

    ms_state_e     state_q;
    logic          ms_valid_q;
    es_to_ms_bus_t bus_q;
    logic [31:0]   ld_buf_q;

    es_to_ms_bus_t es_bus;
    logic          in_need_rsp;
    logic          accept;
    logic          is_load_q;
    logic [31:0]   align_data;
    logic [31:0]   final_result;
    logic          unused_pc;

    assign es_bus      = es_to_ms_bus;
    assign in_need_rsp = (es_bus.ld_w | es_bus.ld_h | es_bus.ld_b | es_bus.lwl | es_bus.lwr)
                         & ~es_bus.ex;
    assign ms_allowin  = (state_q == StIdle) | ((state_q == StDone) & ws_allowin);
    assign accept      = es_to_ms_valid & ms_allowin & ~ex_from_ws;

    ms_load_align u_align (
        .rdata_i    (data_sram_rdata),
        .rt_value_i (bus_q.rt_value),
        .addr_lo_i  (bus_q.addr_lo),
        .ld_w_i     (bus_q.ld_w),
        .ld_h_i     (bus_q.ld_h),
        .ld_b_i     (bus_q.ld_b),
        .ld_sign_i  (bus_q.ld_sign),
        .lwl_i      (bus_q.lwl),
        .lwr_i      (bus_q.lwr),
        .result_o   (align_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            ld_buf_q   <= '0;
        end else if (ex_from_ws) begin
            ms_valid_q <= 1'b0;
            // A response still owed to an in-flight load must be swallowed before reuse.
            if ((state_q == StWait || state_q == StDrop) && !data_sram_rvalid) begin
                state_q <= StDrop;
            end else begin
                state_q <= StIdle;
            end
        end else if (accept) begin
            bus_q      <= es_bus;
            ms_valid_q <= 1'b1;
            state_q    <= in_need_rsp ? StWait : StDone;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (data_sram_rvalid) begin
                        ld_buf_q <= align_data;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (ws_allowin) begin
                        ms_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StDrop: begin
                    if (data_sram_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_load_q    = bus_q.ld_w | bus_q.ld_h | bus_q.ld_b | bus_q.lwl | bus_q.lwr;
    assign final_result = (is_load_q & ~bus_q.ex) ? ld_buf_q : bus_q.alu_result;
    assign unused_pc    = ^bus_q.pc[1:0];

    assign ms_to_ws_valid  = ms_valid_q & (state_q == StDone);
    assign ms_to_ws_bus    = {bus_q.inst_addr_ex, bus_q.eret, bus_q.bd, bus_q.mtc0_we,
                              bus_q.cp0_addr, bus_q.ex, bus_q.excode, bus_q.res_from_cp0,
                              bus_q.gr_we & ~bus_q.ex, bus_q.dest, final_result,
                              bus_q.pc[31:2]};
    assign ex_from_ms      = ms_valid_q & bus_q.ex;
    assign ms_forward_data = final_result;
    assign ms_dest         = (ms_valid_q & bus_q.gr_we) ? bus_q.dest : 5'd0;
    assign ms_res_from_mem = ms_valid_q & (state_q == StWait);
    assign ms_res_from_cp0 = ms_valid_q & bus_q.res_from_cp0;
    assign ms_load_stall   = ms_valid_q & (state_q == StWait);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load-alignment table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_stage;
    import mycpu_pkg::*;

    logic                       clk;
    logic                       resetn;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       data_sram_rvalid;
    logic [31:0]                data_sram_rdata;
    logic                       ex_from_ws;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ex_from_ms;
    logic [31:0]                ms_forward_data;
    logic [4:0]                 ms_dest;
    logic                       ms_res_from_mem;
    logic                       ms_res_from_cp0;
    logic                       ms_load_stall;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .ws_allowin       (ws_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .data_sram_rvalid (data_sram_rvalid),
        .data_sram_rdata  (data_sram_rdata),
        .ex_from_ws       (ex_from_ws),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .ex_from_ms       (ex_from_ms),
        .ms_forward_data  (ms_forward_data),
        .ms_dest          (ms_dest),
        .ms_res_from_mem  (ms_res_from_mem),
        .ms_res_from_cp0  (ms_res_from_cp0),
        .ms_load_stall    (ms_load_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iae, eret, bd, mtc0;
        logic [4:0]  cp0a;
        logic        ex;
        logic [4:0]  excode;
        logic        rfc0, lwl, lwr;
        logic [31:0] rt;
        logic        ldw, ldh, ldb, sign;
        logic [1:0]  o;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu, pc;
    } es_fields_t;

    typedef struct packed {
        logic        ldw, ldh, ldb, sign, lwl, lwr;
        logic [1:0]  o;
        logic [31:0] rt, rdata, exp;
    } vec_t;

    typedef struct packed {
        logic [125:0] bus;
        logic [31:0]  rdata;
        logic         need_rsp;
        logic [83:0]  exp_ws;
    } txn_t;

    int n_checks;
    int n_fail;
    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [125:0] pack_es(input es_fields_t f);
        logic [125:0] b;
        b = '0;
        b[EsInstAddrEx] = f.iae;   b[EsEret] = f.eret;   b[EsBd] = f.bd;
        b[EsMtc0We] = f.mtc0;      b[EsCp0Addr +: 5] = f.cp0a;
        b[EsEx] = f.ex;            b[EsExcode +: 5] = f.excode;
        b[EsResFromCp0] = f.rfc0;  b[EsLwl] = f.lwl;  b[EsLwr] = f.lwr;
        b[EsRtValue +: 32] = f.rt; b[EsLdW] = f.ldw;  b[EsLdH] = f.ldh;
        b[EsLdB] = f.ldb;          b[EsLdSign] = f.sign;
        b[EsAddrLo +: 2] = f.o;    b[EsGrWe] = f.gr_we;
        b[EsDest +: 5] = f.dest;   b[EsAluResult +: 32] = f.alu;
        b[EsPc +: 32] = f.pc;
        return b;
    endfunction

    function automatic logic [83:0] exp_ws(input es_fields_t f, input logic [31:0] fin);
        logic [83:0] b;
        b = '0;
        b[MsInstAddrEx] = f.iae;  b[MsEret] = f.eret;  b[MsBd] = f.bd;
        b[MsMtc0We] = f.mtc0;     b[MsCp0Addr +: 5] = f.cp0a;
        b[MsEx] = f.ex;           b[MsExcode +: 5] = f.excode;
        b[MsResFromCp0] = f.rfc0; b[MsGrWe] = f.gr_we & ~f.ex;
        b[MsDest +: 5] = f.dest;  b[MsFinalResult +: 32] = fin;
        b[MsPc +: 30] = f.pc[31:2];
        return b;
    endfunction

    // Shift-and-mask view of the load rules.
    function automatic logic [31:0] ref_align(input es_fields_t f, input logic [31:0] d);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(f.o);
        if (f.ldw) return d;
        if (f.lwl) return (d << (24 - sh)) | (f.rt & (32'hFFFF_FFFF >> (sh + 8)));
        if (f.lwr) return (d >> sh) | (f.rt & ~(32'hFFFF_FFFF >> sh));
        if (f.ldh) begin
            v = (d >> (16 * int'(f.o[1]))) & 32'h0000_FFFF;
            if (f.sign && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        if (f.ldb) begin
            v = (d >> sh) & 32'h0000_00FF;
            if (f.sign && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        return d;
    endfunction

    function automatic vec_t mk_vec(input logic [5:0] kind, input logic [1:0] o,
                                    input logic [31:0] rt, input logic [31:0] rdata,
                                    input logic [31:0] exp);
        vec_t v;
        {v.ldw, v.ldh, v.ldb, v.sign, v.lwl, v.lwr} = kind;
        v.o = o; v.rt = rt; v.rdata = rdata; v.exp = exp;
        return v;
    endfunction

    function automatic txn_t gen_txn();
        es_fields_t f;
        txn_t t;
        int kind;
        logic [31:0] fin;
        f = '0;
        f.iae = 1'($urandom);  f.eret = 1'($urandom); f.bd = 1'($urandom);
        f.mtc0 = 1'($urandom); f.cp0a = 5'($urandom); f.rfc0 = 1'($urandom);
        f.rt = $urandom;       f.o = 2'($urandom);    f.sign = 1'($urandom);
        f.gr_we = 1'($urandom); f.dest = 5'($urandom); f.alu = $urandom; f.pc = $urandom;
        kind = $urandom_range(6, 0);
        f.ldw = (kind == 2); f.ldh = (kind == 3); f.ldb = (kind == 4);
        f.lwl = (kind == 5); f.lwr = (kind == 6);
        f.ex = ($urandom_range(7, 0) == 0);
        f.excode = f.ex ? ExcAdel : 5'($urandom);
        t.rdata = $urandom;
        t.need_rsp = (kind >= 2) && !f.ex;
        fin = t.need_rsp ? ref_align(f, t.rdata) : f.alu;
        t.bus = pack_es(f);
        t.exp_ws = exp_ws(f, fin);
        return t;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " allowin"}, ms_allowin, 1'b1);
        check({tag, " ws_valid"}, ms_to_ws_valid, 1'b0);
        check({tag, " ws_bus"}, ms_to_ws_bus, '0);
        check({tag, " ex_from_ms"}, ex_from_ms, 1'b0);
        check({tag, " fwd"}, ms_forward_data, 32'h0);
        check({tag, " dest"}, ms_dest, 5'd0);
        check({tag, " res_mem"}, ms_res_from_mem, 1'b0);
        check({tag, " res_cp0"}, ms_res_from_cp0, 1'b0);
        check({tag, " stall"}, ms_load_stall, 1'b0);
    endtask

    es_fields_t f, g;
    txn_t nxt, cur;
    logic occ, wt, exp_allow, exp_v;
    int cnt;

    initial begin
        n_checks = 0;
        n_fail = 0;
        resetn = 1'b1; ws_allowin = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_rvalid = 1'b0; data_sram_rdata = '0; ex_from_ws = 1'b0;

        // kind bits: {ld_w, ld_h, ld_b, ld_sign, lwl, lwr}
        vecs[0]  = mk_vec(6'b001100, 2'd2, 32'h0,         32'h1280_3456, 32'hFFFF_FF80);
        vecs[1]  = mk_vec(6'b000010, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
        vecs[2]  = mk_vec(6'b000001, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11);
        vecs[3]  = mk_vec(6'b100000, 2'd0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF);
        vecs[4]  = mk_vec(6'b010000, 2'd2, 32'h0,         32'h8000_1234, 32'h0000_8000);
        vecs[5]  = mk_vec(6'b010100, 2'd0, 32'h0,         32'h0000_F234, 32'hFFFF_F234);
        vecs[6]  = mk_vec(6'b001000, 2'd3, 32'h0,         32'hAB00_0000, 32'h0000_00AB);
        vecs[7]  = mk_vec(6'b000010, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344);
        vecs[8]  = mk_vec(6'b000001, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344);
        vecs[9]  = mk_vec(6'b000010, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD);
        vecs[10] = mk_vec(6'b000001, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233);
        vecs[11] = mk_vec(6'b001100, 2'd1, 32'h0,         32'h0000_7F00, 32'h0000_007F);

        #1 resetn = 1'b0;
        #2 check_idle("reset");
        tick(); tick();
        resetn = 1'b1;

        // Non-load: visible in the cycle right after the accept edge, held under backpressure.
        f = '0; f.gr_we = 1'b1; f.dest = 5'd7; f.alu = 32'h1234_5678; f.pc = 32'hBFC0_0100;
        f.rfc0 = 1'b1; f.cp0a = 5'd12; f.bd = 1'b1;
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f); ws_allowin = 1'b0;
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("alu valid", ms_to_ws_valid, 1'b1);
        check("alu fwd", ms_forward_data, f.alu);
        check("alu dest", ms_dest, 5'd7);
        check("alu cp0", ms_res_from_cp0, 1'b1);
        check("alu bus", ms_to_ws_bus, exp_ws(f, f.alu));
        check("alu stall", ms_load_stall, 1'b0);
        check("alu allowin", ms_allowin, 1'b0);
        tick();
        ws_allowin = 1'b1;
        @(negedge clk);
        check("alu allowin2", ms_allowin, 1'b1);
        tick();
        @(negedge clk);
        check("alu retired", ms_to_ws_valid, 1'b0);
        check("alu dest0", ms_dest, 5'd0);
        tick();

        // Load-alignment table with a sync-SRAM (k=0) response.
        for (int i = 0; i < 12; i++) begin
            f = '0;
            {f.ldw, f.ldh, f.ldb, f.sign, f.lwl, f.lwr} =
                {vecs[i].ldw, vecs[i].ldh, vecs[i].ldb, vecs[i].sign, vecs[i].lwl, vecs[i].lwr};
            f.o = vecs[i].o; f.rt = vecs[i].rt; f.gr_we = 1'b1; f.dest = 5'(i + 1);
            f.alu = 32'h1000_0000 + 32'(i * 4) + 32'(vecs[i].o); f.pc = 32'hBFC0_0000 + 32'(i * 4);
            es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f); ws_allowin = 1'b1;
            tick();
            es_to_ms_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d stall", i), ms_load_stall, 1'b1);
            check($sformatf("vec%0d res_mem", i), ms_res_from_mem, 1'b1);
            check($sformatf("vec%0d early", i), ms_to_ws_valid, 1'b0);
            tick();
            data_sram_rvalid = 1'b0; data_sram_rdata = 32'h0;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), ms_to_ws_valid, 1'b1);
            check($sformatf("vec%0d result", i), ms_forward_data, vecs[i].exp);
            check($sformatf("vec%0d bus", i), ms_to_ws_bus, exp_ws(f, vecs[i].exp));
            tick();
        end

        // Backpressure: completed load held for 3 cycles, then retire with same-cycle accept.
        f = '0; f.ldw = 1'b1; f.gr_we = 1'b1; f.dest = 5'd20; f.alu = 32'h0000_2000;
        f.pc = 32'hBFC0_0200;
        ws_allowin = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f);
        tick();
        es_to_ms_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        tick();
        data_sram_rvalid = 1'b0; data_sram_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp valid", ms_to_ws_valid, 1'b1);
            check("bp allowin", ms_allowin, 1'b0);
            check("bp bus", ms_to_ws_bus, exp_ws(f, 32'hCAFE_F00D));
            tick();
        end
        g = '0; g.gr_we = 1'b1; g.dest = 5'd21; g.alu = 32'h7777_0001; g.pc = 32'hBFC0_0204;
        ws_allowin = 1'b1; es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(g);
        @(negedge clk);
        check("bp retire allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("bp next valid", ms_to_ws_valid, 1'b1);
        check("bp next bus", ms_to_ws_bus, exp_ws(g, g.alu));
        tick();

        // Load with an address exception: no wait, gr_we dropped.
        f = '0; f.ldw = 1'b1; f.ex = 1'b1; f.excode = ExcAdel; f.gr_we = 1'b1; f.dest = 5'd9;
        f.alu = 32'h0000_1003; f.pc = 32'hBFC0_0300;
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f);
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("exld ex_from_ms", ex_from_ms, 1'b1);
        check("exld valid", ms_to_ws_valid, 1'b1);
        check("exld stall", ms_load_stall, 1'b0);
        check("exld gr_we", ms_to_ws_bus[MsGrWe], 1'b0);
        check("exld bus", ms_to_ws_bus, exp_ws(f, f.alu));
        tick();

        // Flush while waiting: the next response is swallowed and nothing reaches write-back.
        f = '0; f.ldw = 1'b1; f.gr_we = 1'b1; f.dest = 5'd4; f.alu = 32'h0000_3000;
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f);
        tick();
        es_to_ms_valid = 1'b0; ex_from_ws = 1'b1;
        @(negedge clk);
        check("flush stall", ms_load_stall, 1'b1);
        tick();
        ex_from_ws = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(g);
        @(negedge clk);
        check("drop allowin", ms_allowin, 1'b0);
        check("drop valid", ms_to_ws_valid, 1'b0);
        tick();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1111_2222;
        @(negedge clk);
        check("drop rsp allowin", ms_allowin, 1'b0);
        check("drop rsp valid", ms_to_ws_valid, 1'b0);
        tick();
        data_sram_rvalid = 1'b0; es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("post drop allowin", ms_allowin, 1'b1);
        check("post drop valid", ms_to_ws_valid, 1'b0);
        check("post drop stall", ms_load_stall, 1'b0);
        tick();

        // Flush in DONE with an offered instruction: the offer is ignored.
        ws_allowin = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(g);
        tick();
        f = g; f.dest = 5'd30;
        ws_allowin = 1'b1; es_to_ms_bus = pack_es(f); ex_from_ws = 1'b1;
        @(negedge clk);
        check("fdone valid", ms_to_ws_valid, 1'b1);
        tick();
        ex_from_ws = 1'b0; es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("fdone cleared", ms_to_ws_valid, 1'b0);
        check("fdone dest", ms_dest, 5'd0);
        tick();

        // Asynchronous reset in the middle of a wait.
        f = '0; f.ldb = 1'b1; f.gr_we = 1'b1; f.dest = 5'd6; f.alu = 32'h0000_4001;
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(f);
        tick();
        es_to_ms_valid = 1'b0;
        #2 check("pre rst stall", ms_load_stall, 1'b1);
        resetn = 1'b0;
        #1 check_idle("async rst");
        tick();
        resetn = 1'b1;
        tick();

        // Randomized traffic against a transaction-level model.
        occ = 1'b0; wt = 1'b0; cnt = 0; cur = '0;
        for (int c = 0; c < 3000; c++) begin
            nxt = gen_txn();
            es_to_ms_valid = ($urandom_range(2, 0) != 0);
            es_to_ms_bus = nxt.bus;
            ws_allowin = ($urandom_range(3, 0) != 0);
            data_sram_rvalid = occ && wt && (cnt == 0);
            data_sram_rdata = data_sram_rvalid ? cur.rdata : $urandom;
            @(negedge clk);
            exp_allow = !occ || (!wt && ws_allowin);
            exp_v = occ && !wt;
            check("rnd allowin", ms_allowin, exp_allow);
            check("rnd valid", ms_to_ws_valid, exp_v);
            check("rnd stall", ms_load_stall, occ && wt);
            if (exp_v) check("rnd bus", ms_to_ws_bus, cur.exp_ws);
            if (data_sram_rvalid) wt = 1'b0;
            else if (wt) cnt--;
            if (exp_v && ws_allowin) occ = 1'b0;
            if (es_to_ms_valid && exp_allow) begin
                occ = 1'b1;
                cur = nxt;
                wt = nxt.need_rsp;
                cnt = $urandom_range(3, 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage. It sits between the execute stage and write-back, and takes the execute-to-memory bus. It waits for the data-SRAM read response on loads, then aligns and extends the returned word for lw/lh/lb/lwl/lwr. It forwards its result to execute, raises the memory-stage exception flag, and hands a registered bus to write-back with a valid/allowin handshake.

## Interface
- `ES_TO_MS_BUS_WD`, 126: incoming bus width.
  - [125] inst_addr_ex, [124] eret, [123] bd, [122] mtc0_we, [121:117] cp0_addr, [116] ex, [115:111] excode, [110] res_from_cp0.
  - [109] lwl, [108] lwr, [107:76] rt_value, [75] ld_w, [74] ld_h, [73] ld_b, [72] ld_sign, [71:70] addr_lo, [69] gr_we, [68:64] dest, [63:32] alu_result, [31:0] pc.
- `MS_TO_WS_BUS_WD`, 84: outgoing bus width.
  - [83] inst_addr_ex, [82] eret, [81] bd, [80] mtc0_we, [79:75] cp0_addr, [74] ex, [73:69] excode, [68] res_from_cp0, [67] gr_we, [66:62] dest, [61:30] final_result, [29:0] pc[31:2].

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ws_allowin` in 1: write-back can accept.
- `ms_allowin` out 1: stage can accept from execute.
- `es_to_ms_valid` in 1: execute has valid data.
- `es_to_ms_bus` in ES_TO_MS_BUS_WD: execute payload.
- `data_sram_rvalid` in 1: one-cycle pulse; read data is valid this cycle.
- `data_sram_rdata` in 32: read data.
- `ex_from_ws` in 1: flush from write-back.
- `ms_to_ws_valid` out 1: valid toward write-back.
- `ms_to_ws_bus` out MS_TO_WS_BUS_WD: payload to write-back.
- `ex_from_ms` out 1: `ms_valid & ex`.
- `ms_forward_data` out 32: final_result, for execute forwarding.
- `ms_dest` out 5: `dest` when `ms_valid & gr_we`, else 0.
- `ms_res_from_mem` out 1: valid load, not yet completed.
- `ms_res_from_cp0` out 1: `ms_valid & res_from_cp0`.
- `ms_load_stall` out 1: `ms_valid` and state is WAIT.

## Operation
- `is_load` = ld_w|ld_h|ld_b|lwl|lwr. `need_rsp` = is_load & ~ex. Exactly one read response arrives per accepted need_rsp instruction, in order, at most one outstanding.
- FSM:
  - IDLE:
    - Accept when `es_to_ms_valid & ms_allowin`. Latch the bus and set `ms_valid`.
    - Go to WAIT if need_rsp. Otherwise go to DONE; its result is the alu_result or cp0 path.
  - WAIT: on rvalid, capture aligned data into `ld_buf` and go to DONE.
  - DONE: `ms_to_ws_valid=1`. On `ws_allowin`, retire.
    - If a new instruction is accepted in the same cycle, go to WAIT or DONE accordingly.
    - Otherwise clear `ms_valid` and go to IDLE.
  - DROP: flushed while WAIT. Discard the next rvalid, then go to IDLE.
    - `ms_allowin=0` in DROP.
- `ms_allowin` = IDLE, or (DONE & ws_allowin).
- `ex_from_ws`: clear `ms_valid`; WAIT→DROP, any other state→IDLE. In the same cycle, `es_to_ms_valid` is ignored.
- An rvalid arriving in IDLE or DONE is a protocol error. Ignore it.
- Load alignment, with o = addr_lo, d = rdata, r = rt_value:
  - lw: d.
  - lh: half d[31:16] if o[1] else d[15:0]; sign-extend if ld_sign, else zero-extend.
  - lb: byte d[8o+7:8o]; extended the same way.
  - lwl:
    - o=0: {d[7:0], r[23:0]}
    - o=1: {d[15:0], r[15:0]}
    - o=2: {d[23:0], r[7:0]}
    - o=3: d
  - lwr:
    - o=0: d
    - o=1: {r[31:24], d[31:8]}
    - o=2: {r[31:16], d[31:16]}
    - o=3: {r[31:8], d[31:24]}
- final_result = `ld_buf` if is_load & ~ex, else alu_result. Cp0 read data is merged in write-back.
- On ex=1, gr_we is forced to 0 on the outgoing bus.

## Timing
- Reset: state=IDLE, `ms_valid=0`, bus register=0, `ld_buf=0`. All outputs are 0 except `ms_allowin=1`.
- Non-load latency: accepted at edge N, `ms_to_ws_valid` high in cycle N.
- Load latency: rvalid in cycle N+k gives `ms_to_ws_valid` from cycle N+k+1.
  - Sync SRAM (k=0): one stall cycle.
- `ms_res_from_mem`/`ms_load_stall` are high throughout WAIT, so execute and decode can interlock on load-use.
- A bus held in DONE is stable until retired.

## Structure
- Package `mycpu_pkg`: both bus widths, bus field offset constants, the FSM state enum (IDLE/WAIT/DONE/DROP), and excode constants (AdEL 0x04, AdES 0x05, Ov 0x0c).
- Sub-module `ms_load_align`: combinational, (rdata, rt_value, addr_lo, ld_w/h/b, ld_sign, lwl, lwr) → 32-bit result.

## Test plan
- lb, ld_sign=1, o=2, rdata=0x1280_3456, one-cycle rvalid → final_result 0xFFFF_FF80 one cycle after rvalid.
- lwl o=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → 0x3344_CCDD. lwr o=3 with the same inputs → 0xAABB_CC11.
- Backpressure: load completes while ws_allowin=0 for 3 cycles → bus held stable, `ms_allowin=0`; retires on the first ws_allowin=1, with a same-cycle accept.
- Flush in WAIT: ex_from_ws, then rvalid 2 cycles later → no `ms_to_ws_valid`, `ms_allowin` 0 until after the discarded rvalid.
- Load with ex=1, excode 0x04 → no wait, `ex_from_ms=1` immediately, gr_we=0 outgoing.
- resetn asserted mid-WAIT → IDLE, all outputs at reset values asynchronously.
